// File: rtl/multi_phase_traffic_controller_pkg.sv
// Shared types, lamp codes and phase-selection helper for the traffic controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    PED     = 2'd1,
    GREEN   = 2'd2,
    YELLOW  = 2'd3
  } state_t;

  localparam logic [2:0] LIGHT_RED    = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b100;

  // Round-robin search starting after p; a search of n includes p itself.
  // With no demand at all, the phase after p is served.
  function automatic logic [2:0] next_phase(input logic [7:0] car,
                                            input logic [2:0] p,
                                            input int unsigned n);
    logic [2:0]  sel;
    logic        found;
    int unsigned idx;
    sel   = 3'((32'(p) + 1) % n);
    found = 1'b0;
    for (int unsigned k = 1; k <= 8; k++) begin
      if (k <= n && !found) begin
        idx = (32'(p) + k) % n;
        if (car[idx[2:0]]) begin
          sel   = idx[2:0];
          found = 1'b1;
        end
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/multi_phase_traffic_controller_timer.sv
// Tick-driven interval down-counter; never wraps below zero.
module phase_timer #(
  parameter int unsigned TIMER_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               tick,
  output logic [TIMER_W-1:0] count,
  output logic               done
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  // Load takes priority; otherwise decrement on tick while nonzero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign done  = (count_q == '0) && tick;

endmodule

// File: rtl/multi_phase_traffic_controller.sv
// N-phase intersection controller with round-robin demand selection and
// a latched all-way pedestrian interval.
module multi_phase_traffic_controller
  import traffic_pkg::*;
#(
  parameter  int unsigned N_PHASES     = 2,
  parameter  int unsigned TIMER_W      = 8,
  parameter  int unsigned GREEN_TICKS  = 10,
  parameter  int unsigned YELLOW_TICKS = 5,
  parameter  int unsigned PED_TICKS    = 15,
  localparam int unsigned PHASE_W      = (N_PHASES <= 2) ? 1 : $clog2(N_PHASES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [N_PHASES-1:0]   car,
  input  logic                  ped,
  output logic [3*N_PHASES-1:0] light,
  output logic [N_PHASES-1:0]   light_ped,
  output logic [PHASE_W-1:0]    phase,
  output logic                  ped_pending
);

  localparam logic [TIMER_W-1:0] GREEN_LOAD  = TIMER_W'(GREEN_TICKS - 1);
  localparam logic [TIMER_W-1:0] YELLOW_LOAD = TIMER_W'(YELLOW_TICKS - 1);
  localparam logic [TIMER_W-1:0] PED_LOAD    = TIMER_W'(PED_TICKS - 1);

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               ped_pending_q, ped_pending_d;
  logic               load;
  logic [TIMER_W-1:0] load_val;
  logic               done;
  logic [TIMER_W-1:0] timer_count_unused;
  logic [PHASE_W-1:0] sel_phase;

  phase_timer #(
    .TIMER_W(TIMER_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .load_val(load_val),
    .tick    (tick),
    .count   (timer_count_unused),
    .done    (done)
  );

  assign sel_phase = PHASE_W'(next_phase(8'(car), 3'(phase_q), N_PHASES));

  // Next state, phase selection on GREEN entry, and timer reload.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    load     = 1'b0;
    load_val = '0;
    case (state_q)
      ALL_RED: begin
        state_d  = PED;
        load     = 1'b1;
        load_val = PED_LOAD;
      end
      PED: begin
        if (done) begin
          state_d  = GREEN;
          phase_d  = sel_phase;
          load     = 1'b1;
          load_val = GREEN_LOAD;
        end
      end
      GREEN: begin
        if (done) begin
          state_d  = YELLOW;
          load     = 1'b1;
          load_val = YELLOW_LOAD;
        end
      end
      YELLOW: begin
        if (done) begin
          load = 1'b1;
          if (ped_pending_q || ped) begin
            state_d  = PED;
            load_val = PED_LOAD;
          end else begin
            state_d  = GREEN;
            phase_d  = sel_phase;
            load_val = GREEN_LOAD;
          end
        end
      end
      default: state_d = ALL_RED;
    endcase
  end

  // Pedestrian latch: cleared on PED entry, requests during PED ignored.
  always_comb begin
    ped_pending_d = ped_pending_q;
    if (state_d == PED && state_q != PED) begin
      ped_pending_d = 1'b0;
    end else if (ped && state_q != PED) begin
      ped_pending_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ALL_RED;
      phase_q       <= PHASE_W'(N_PHASES - 1);
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  // Moore lamp decode.
  always_comb begin
    light     = '0;
    light_ped = '0;
    for (int unsigned i = 0; i < N_PHASES; i++) begin
      light[3*i +: 3] = LIGHT_RED;
      if (state_q == PED) begin
        light_ped[i] = 1'b1;
      end else if (phase_q == PHASE_W'(i)) begin
        if (state_q == GREEN) begin
          light[3*i +: 3] = LIGHT_GREEN;
          light_ped[i]    = 1'b1;
        end else if (state_q == YELLOW) begin
          light[3*i +: 3] = LIGHT_YELLOW;
          light_ped[i]    = 1'b1;
        end
      end
    end
  end

  assign phase       = phase_q;
  assign ped_pending = ped_pending_q;

endmodule

// File: tb/tb_multi_phase_traffic_controller.sv
// Scoreboard bench: stimulus pushes model predictions, monitor compares.
module tb_multi_phase_traffic_controller;

  localparam int unsigned N = 3;
  localparam int unsigned G = 4;
  localparam int unsigned Y = 2;
  localparam int unsigned P = 3;

  localparam int K_RED     = 0;
  localparam int K_WALK    = 1;
  localparam int K_GO      = 2;
  localparam int K_CAUTION = 3;

  typedef struct {
    int unsigned due;
    logic [8:0]  light;
    logic [2:0]  lped;
    logic [1:0]  phase;
    logic        pend;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, ped, tick;
  logic [2:0] car;
  logic [8:0] light;
  logic [2:0] light_ped;
  logic [1:0] phase;
  logic       ped_pending;

  int unsigned cyc = 0;
  int unsigned n_assert = 0;
  int unsigned n_fail = 0;
  exp_t        exp_q[$];

  int          m_kind;
  int unsigned m_left;
  int unsigned m_phase;
  bit          m_pend;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_phase_traffic_controller #(
    .N_PHASES    (N),
    .TIMER_W     (8),
    .GREEN_TICKS (G),
    .YELLOW_TICKS(Y),
    .PED_TICKS   (P)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .car        (car),
    .ped        (ped),
    .light      (light),
    .light_ped  (light_ped),
    .phase      (phase),
    .ped_pending(ped_pending)
  );

  function automatic int unsigned serve(input logic [2:0] c, input int unsigned from);
    for (int unsigned k = 1; k <= N; k++) begin
      if (c[(from + k) % N]) return (from + k) % N;
    end
    return (from + 1) % N;
  endfunction

  // Reference model: each timed interval lasts a fixed number of ticks.
  task automatic step_model(input bit r, input logic [2:0] c, input bit pd, input bit tk);
    int nk;
    bit enter_walk;
    if (r) begin
      m_kind  = K_RED;
      m_phase = N - 1;
      m_pend  = 1'b0;
      m_left  = 0;
      return;
    end
    nk         = m_kind;
    enter_walk = 1'b0;
    if (m_kind == K_RED) begin
      nk         = K_WALK;
      m_left     = P;
      enter_walk = 1'b1;
    end else if (tk) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (m_kind == K_WALK) begin
          nk      = K_GO;
          m_phase = serve(c, m_phase);
          m_left  = G;
        end else if (m_kind == K_GO) begin
          nk     = K_CAUTION;
          m_left = Y;
        end else if (m_pend || pd) begin
          nk         = K_WALK;
          m_left     = P;
          enter_walk = 1'b1;
        end else begin
          nk      = K_GO;
          m_phase = serve(c, m_phase);
          m_left  = G;
        end
      end
    end
    if (enter_walk) m_pend = 1'b0;
    else if (pd && m_kind != K_WALK) m_pend = 1'b1;
    m_kind = nk;
  endtask

  task automatic push_expect();
    exp_t e;
    e.due   = cyc + 1;
    e.light = 9'b001_001_001;
    e.lped  = 3'b000;
    if (m_kind == K_WALK) e.lped = 3'b111;
    if (m_kind == K_GO) begin
      e.light[3*m_phase +: 3] = 3'b100;
      e.lped[m_phase]         = 1'b1;
    end
    if (m_kind == K_CAUTION) begin
      e.light[3*m_phase +: 3] = 3'b010;
      e.lped[m_phase]         = 1'b1;
    end
    e.phase = 2'(m_phase);
    e.pend  = m_pend;
    exp_q.push_back(e);
  endtask

  task automatic do_cycle(input bit r, input logic [2:0] c, input bit pd, input bit tk);
    @(posedge clk);
    #1;
    rst  = r;
    car  = c;
    ped  = pd;
    tick = tk;
    step_model(r, c, pd, tk);
    push_expect();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_assert++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, want);
    end
  endtask

  // Monitor: compare every output against the prediction due this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("light",       32'(light),       32'(e.light));
      chk("light_ped",   32'(light_ped),   32'(e.lped));
      chk("phase",       32'(phase),       32'(e.phase));
      chk("ped_pending", 32'(ped_pending), 32'(e.pend));
    end
  end

  initial begin
    bit          hit;
    bit          pd;
    logic [2:0]  c;
    rst  = 1'b1;
    car  = '0;
    ped  = 1'b0;
    tick = 1'b1;

    repeat (2) do_cycle(1'b1, 3'b000, 1'b0, 1'b1);
    // Idle rotation.
    repeat (40) do_cycle(1'b0, 3'b000, 1'b0, 1'b1);
    // Sole demand on phase 2.
    repeat (30) do_cycle(1'b0, 3'b100, 1'b0, 1'b1);
    // Random demand, ped sometimes on the last yellow cycle.
    for (int i = 0; i < 200; i++) begin
      c  = 3'($urandom);
      pd = ($urandom_range(0, 9) == 0) ||
           (m_kind == K_CAUTION && m_left == 1 && !m_pend && $urandom_range(0, 1) == 1);
      do_cycle(1'b0, c, pd, 1'b1);
    end
    // Tick every 4th cycle.
    for (int i = 0; i < 160; i++) begin
      c  = 3'($urandom);
      pd = ($urandom_range(0, 19) == 0);
      do_cycle(1'b0, c, pd, (i % 4) == 3);
    end
    // Reset mid-yellow with a pending request.
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (m_kind == K_CAUTION && m_pend) begin
        do_cycle(1'b1, 3'b000, 1'b0, 1'b1);
        hit = 1'b1;
      end else begin
        do_cycle(1'b0, 3'b000, m_kind == K_GO, 1'b1);
      end
    end
    n_assert++;
    if (!hit) begin
      n_fail++;
      $display("FAIL rst_mid_yellow: got no pending yellow within bound, required one");
    end
    repeat (30) do_cycle(1'b0, 3'b000, 1'b0, 1'b1);
    // Random everything including occasional reset.
    for (int i = 0; i < 400; i++) begin
      c = 3'($urandom);
      do_cycle($urandom_range(0, 49) == 0, c, $urandom_range(0, 7) == 0,
               $urandom_range(0, 1) == 1);
    end

    repeat (3) @(negedge clk);
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_phase_traffic_controller.md
# multi_phase_traffic_controller

Parametrised successor to the two-way intersection controller: sequences N_PHASES mutually exclusive traffic phases plus an all-way pedestrian interval. It integrates its own tick-driven down-counter in place of the external timer handshake. It adds car-demand round-robin phase selection and a latched pedestrian request. It sits between the sensor/button synchronisers and the lamp drivers, clocked by the system clock with a 1 Hz `tick` strobe.

## Interface
- N_PHASES, 2, number of conflicting traffic phases (legal 2..8)
- TIMER_W, 8, width of interval counter
- GREEN_TICKS, 10, green duration in ticks (1..2^TIMER_W)
- YELLOW_TICKS, 5, yellow duration in ticks (1..2^TIMER_W)
- PED_TICKS, 15, all-way walk duration in ticks (1..2^TIMER_W)
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle timing strobe; durations count these
- car  in  N_PHASES  level demand per phase, bit i = phase i
- ped  in  1  pedestrian request pulse or level
- light  out  3*N_PHASES  per-phase lamp, bits [3i+2:3i]: 001 red, 010 yellow, 100 green
- light_ped  out  N_PHASES  per-phase walk signal
- phase  out  PHASE_W=max(1,clog2(N_PHASES))  currently selected / last served phase
- ped_pending  out  1  latched pedestrian request

## Operation
- States: ALL_RED, PED, GREEN, YELLOW.
- ALL_RED: entered on reset; lasts exactly one clk cycle regardless of tick; then PED.
- PED: all lights red, light_ped all ones; lasts PED_TICKS ticks; then GREEN of selected phase.
- GREEN: light[phase]=100, others 001, light_ped[phase]=1, others 0; lasts GREEN_TICKS ticks; then YELLOW.
- YELLOW: light[phase]=010, others 001, light_ped[phase]=1; lasts YELLOW_TICKS ticks.
  - At expiry, if ped_pending or ped is set: go to PED.
  - Otherwise: go to GREEN of the next selected phase.
- Phase selection, performed on every entry to GREEN, with p = phase:
  - Search (p+1)..(p+N_PHASES) mod N_PHASES for the first phase with its car bit set; that phase is served.
  - A search of N_PHASES includes p itself, so a sole-demand phase is re-served.
  - If no car bit is set, serve (p+1) mod N_PHASES.
- phase updates on GREEN entry and holds through YELLOW and PED.
- ped_pending:
  - Set by ped in any state except PED.
  - Cleared on the cycle PED is entered.
  - ped asserted while in PED is ignored.
- All outputs are Moore functions of registered state/phase/ped_pending.

## Timing
- Reset values: state ALL_RED, phase N_PHASES-1 (so phase 0 is served first when idle), counter 0, ped_pending 0.
- Output values in reset: light all 001, light_ped all 0.
- Interval counter, on entry to a timed state, loads duration-1.
- Within a timed state:
  - If tick and count==0: transition, and load the next state's duration-1 on the same edge.
  - Else if tick: decrement.
  - Else: hold.
- With tick tied high, GREEN lasts exactly GREEN_TICKS cycles, YELLOW YELLOW_TICKS, PED PED_TICKS.
- car is sampled only at the GREEN-entry edge; changes mid-green have no effect; no early termination.
- ped on the same cycle as YELLOW expiry is honoured (goes to PED).
- rst mid-operation: next cycle is ALL_RED, counter and ped_pending cleared; the interval is not resumed.
- The counter never wraps: decrement occurs only when count>0.

## Structure
- Package traffic_pkg:
  - state enum.
  - Lamp codes LIGHT_RED/YELLOW/GREEN.
  - Helper function next_phase(car, p, N).
- Sub-module phase_timer (TIMER_W):
  - Inputs: load, load_val, tick.
  - Outputs: count and done = (count==0 && tick).
- The controller FSM and selection logic stay in the top module.

## Test plan
All scenarios use N_PHASES=3, GREEN=4, YELLOW=2, PED=3, tick=1 unless noted.
- Reset release, car=000, ped=0:
  - ALL_RED 1 cycle, then PED 3 cycles with light_ped=111.
  - Then phase0 green 4 / yellow 2, phase1, phase2, phase0 in strict rotation.
- car=100 constant: after PED, phase=2 green.
  - Every subsequent cycle is green 4 / yellow 2 of phase 2; light[5:0] stays 001001.
- ped one-cycle pulse during phase0 GREEN:
  - ped_pending=1 until YELLOW expiry.
  - Then PED 3 cycles with light_ped=111; ped_pending=0 from PED entry.
- ped pulse exactly on the last YELLOW cycle: next state is PED (not GREEN).
- tick asserted every 4th cycle: GREEN lasts 16 clk cycles; counter holds between ticks.
- rst for one cycle mid-YELLOW with ped_pending=1:
  - Next cycle light all 001, light_ped 000, ped_pending 0, phase 2.
  - Sequence then restarts as in the first scenario.
